// File: rtl/hs_byte_aligner_pkg.sv
// Shared HS receive definitions: aligner state encodings, sync position limit
// and the sync character also used by the sync detector.
package hs_byte_aligner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_ACTIVE = 2'd2
  } hs_state_e;

  localparam int         HS_SYNC_POS_MAX = 8;
  localparam logic [7:0] HS_SYNC_CHAR    = 8'h1D;

endpackage

// File: rtl/hs_byte_aligner_align_mux.sv
// Combinational 16-to-8 offset select over a two-byte window; also used by the
// multi-lane merger.
module hs_align_mux
  import hs_byte_aligner_pkg::*;
(
  input  logic [15:0] win,
  input  logic [3:0]  offset,
  output logic [7:0]  aligned
);

  logic [15:0] shifted;

  assign shifted = win >> offset;
  assign aligned = shifted[7:0];

endmodule

// File: rtl/hs_byte_aligner.sv
// HS byte aligner: locks the sync bit offset per burst and streams aligned payload.
// Optional HS_ALIGN_ERR_EN adds the ErrSyncHS pulse for illegal or repeated syncs.
module hs_byte_aligner
  import hs_byte_aligner_pkg::*;
#(
  parameter int SYNC_POS_MAX = HS_SYNC_POS_MAX,
  parameter int CNT_W        = 16
) (
  input  logic             RxByteClkHS,
  input  logic             Rst_n,
  input  logic             Enable,
  input  logic [7:0]       DataHS,
  input  logic             RxSyncHS,
  input  logic [3:0]       RxSyncPosition,
  output logic [7:0]       RxDataHS,
  output logic             RxValidHS,
  output logic             RxActiveHS,
  output logic [CNT_W-1:0] RxByteCount
`ifdef HS_ALIGN_ERR_EN
  ,
  output logic             ErrSyncHS
`endif
);

  localparam logic [3:0] POS_MAX = 4'(SYNC_POS_MAX);

  hs_state_e  state;
  logic [3:0] offset;
  logic [7:0] prev_byte;
  logic [7:0] aligned_byte;

  function automatic logic pos_illegal(input logic [3:0] pos);
    return pos > POS_MAX;
  endfunction

  function automatic logic [3:0] clamp_pos(input logic [3:0] pos);
    return pos_illegal(pos) ? POS_MAX : pos;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  // Window is {current byte, previous byte}; first-received bit sits at bit 0.
  hs_align_mux u_align_mux (
    .win     ({DataHS, prev_byte}),
    .offset  (offset),
    .aligned (aligned_byte)
  );

  always_ff @(posedge RxByteClkHS or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= ST_IDLE;
      offset      <= '0;
      prev_byte   <= '0;
      RxDataHS    <= '0;
      RxValidHS   <= 1'b0;
      RxActiveHS  <= 1'b0;
      RxByteCount <= '0;
`ifdef HS_ALIGN_ERR_EN
      ErrSyncHS   <= 1'b0;
`endif
    end else begin
      RxValidHS <= 1'b0;
`ifdef HS_ALIGN_ERR_EN
      ErrSyncHS <= 1'b0;
`endif
      if (Enable) begin
        prev_byte <= DataHS;
      end
      // Dropping Enable ends the burst and wins over any sync in the same cycle.
      if (!Enable) begin
        state      <= ST_IDLE;
        RxActiveHS <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_HUNT;
          ST_HUNT: begin
            if (RxSyncHS) begin
`ifdef HS_ALIGN_ERR_EN
              if (pos_illegal(RxSyncPosition)) begin
                ErrSyncHS <= 1'b1;
              end else begin
                state       <= ST_ACTIVE;
                RxActiveHS  <= 1'b1;
                offset      <= RxSyncPosition;
                RxByteCount <= '0;
              end
`else
              state       <= ST_ACTIVE;
              RxActiveHS  <= 1'b1;
              offset      <= clamp_pos(RxSyncPosition);
              RxByteCount <= '0;
`endif
            end
          end
          ST_ACTIVE: begin
            RxDataHS    <= aligned_byte;
            RxValidHS   <= 1'b1;
            RxByteCount <= sat_inc(RxByteCount);
`ifdef HS_ALIGN_ERR_EN
            ErrSyncHS   <= RxSyncHS;
`endif
          end
          default: begin
            state      <= ST_IDLE;
            RxActiveHS <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hs_byte_aligner.sv
// Scoreboard bench for hs_byte_aligner: a default instance and a CNT_W=4 instance
// share one stimulus stream; aligned bytes are queued as they are driven.
`timescale 1ns/1ps
module tb_hs_byte_aligner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       sync;
  logic [3:0] pos;
  logic [7:0] data;

  logic [7:0]  rx_data, rx_data_s;
  logic        vld, vld_s, act, act_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;
`ifdef HS_ALIGN_ERR_EN
  logic        err, err_s;
`endif

  typedef struct {
    logic [7:0] data;
    int         cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] bytes [0:31];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  hs_byte_aligner dut (
    .RxByteClkHS    (clk),
    .Rst_n          (rst_n),
    .Enable         (en),
    .DataHS         (data),
    .RxSyncHS       (sync),
    .RxSyncPosition (pos),
    .RxDataHS       (rx_data),
    .RxValidHS      (vld),
    .RxActiveHS     (act),
    .RxByteCount    (cnt)
`ifdef HS_ALIGN_ERR_EN
    ,
    .ErrSyncHS      (err)
`endif
  );

  hs_byte_aligner #(.CNT_W(4)) dut_s (
    .RxByteClkHS    (clk),
    .Rst_n          (rst_n),
    .Enable         (en),
    .DataHS         (data),
    .RxSyncHS       (sync),
    .RxSyncPosition (pos),
    .RxDataHS       (rx_data_s),
    .RxValidHS      (vld_s),
    .RxActiveHS     (act_s),
    .RxByteCount    (cnt_s)
`ifdef HS_ALIGN_ERR_EN
    ,
    .ErrSyncHS      (err_s)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic e, input logic s, input logic [3:0] p, input logic [7:0] d);
    en   = e;
    sync = s;
    pos  = p;
    data = d;
    @(posedge clk);
    #1;
  endtask

  // Lock with position p on bytes[0], stream bytes[1..n], then drop Enable.
  task automatic run_burst(input logic [3:0] p, input int n, input int resync_at,
                           input logic end_sync);
    logic [3:0]  off;
    logic [15:0] w;
    off = (p > 4'd8) ? 4'd8 : p;
    step(1'b1, 1'b0, 4'd0, 8'h00);
    chk("hunt_inactive", act, 0);
    step(1'b1, 1'b1, p, bytes[0]);
    chk("lock_active", act, 1);
    chk("lock_count_clr", cnt, 0);
    chk("lock_no_valid", vld, 0);
    for (int i = 1; i <= n; i++) begin
      w = {bytes[i], bytes[i-1]} >> off;
      exp_q.push_back('{w[7:0], i});
      step(1'b1, i == resync_at, 4'd2, bytes[i]);
      chk("burst_active", act, 1);
`ifdef HS_ALIGN_ERR_EN
      chk("resync_err", err, (i == resync_at) ? 1 : 0);
`endif
    end
    step(1'b0, end_sync, 4'd1, 8'hFF);
    chk("end_valid", vld, 0);
    chk("end_active", act, 0);
    chk("end_count", cnt, n);
    chk("drain", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (vld) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", vld, 0);
      end else begin
        e = exp_q.pop_front();
        chk("data", rx_data, e.data);
        chk("count", cnt, e.cnt);
        chk("valid_sat", vld_s, 1);
        chk("data_sat", rx_data_s, e.data);
        chk("count_sat", cnt_s, (e.cnt > 15) ? 15 : e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    rst_n = 1'b0;
    en    = 1'b0;
    sync  = 1'b0;
    pos   = 4'd0;
    data  = 8'h00;
    #2;
    chk("rst_active", act, 0);
    chk("rst_valid", vld, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_count", cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Offset 8: payload passes straight through with one cycle latency
    bytes[0] = 8'h77; bytes[1] = 8'hA5; bytes[2] = 8'h3C;
    run_burst(4'd8, 2, 0, 1'b0);
    chk("offset8_hold", rx_data, 8'h3C);

    // Offset 4: {3C, A5}[4 +: 8] = CA
    bytes[0] = 8'hA5; bytes[1] = 8'h3C;
    run_burst(4'd4, 1, 0, 1'b0);
    chk("offset4_data", rx_data, 8'hCA);

    // End of burst with a sync in the Enable-low cycle
    for (int i = 0; i < 32; i++) bytes[i] = 8'($urandom);
    run_burst(4'd3, 5, 0, 1'b1);
    step(1'b1, 1'b0, 4'd0, 8'h00);
    chk("end_sync_no_lock", act, 0);
    chk("end_count_hold", cnt, 5);
    step(1'b0, 1'b0, 4'd0, 8'h00);

    // Illegal sync position
`ifdef HS_ALIGN_ERR_EN
    step(1'b1, 1'b0, 4'd0, 8'h00);
    step(1'b1, 1'b1, 4'd9, 8'h12);
    chk("illegal_err", err, 1);
    chk("illegal_hunt", act, 0);
    step(1'b1, 1'b0, 4'd0, 8'h34);
    chk("illegal_err_clr", err, 0);
    chk("illegal_still_hunt", act, 0);
    step(1'b0, 1'b0, 4'd0, 8'h00);
`else
    bytes[0] = 8'h12; bytes[1] = 8'h34;
    run_burst(4'd9, 1, 0, 1'b0);
    chk("clamp_offset8", rx_data, 8'h34);
`endif

    // Re-sync while ACTIVE: offset and count unaffected
    for (int i = 0; i < 32; i++) bytes[i] = 8'($urandom);
    run_burst(4'd5, 4, 2, 1'b0);

    // Counter saturation on the narrow instance
    for (int i = 0; i < 32; i++) bytes[i] = 8'($urandom);
    run_burst(4'd3, 20, 0, 1'b0);
    chk("sat_hold", cnt_s, 4'hF);

    // Asynchronous reset in the middle of a burst
    step(1'b1, 1'b0, 4'd0, 8'h11);
    step(1'b1, 1'b1, 4'd6, 8'h22);
    w = {8'h33, 8'h22} >> 6;
    exp_q.push_back('{w[7:0], 1});
    step(1'b1, 1'b0, 4'd0, 8'h33);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_active", act, 0);
    chk("midrst_valid", vld, 0);
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_count", cnt, 0);
`ifdef HS_ALIGN_ERR_EN
    chk("midrst_err", err, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 4'd0, 8'(8'h40 + i));
      chk("post_rst_hunt", act, 0);
    end
    step(1'b1, 1'b1, 4'd0, 8'h5A);
    chk("post_rst_lock", act, 1);
    exp_q.push_back('{8'h5A, 1});
    step(1'b1, 1'b0, 4'd0, 8'hC3);
    step(1'b0, 1'b0, 4'd0, 8'h00);
    chk("post_rst_count", cnt, 1);

    chk("final_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_byte_aligner.md
# hs_byte_aligner

- Sits directly downstream of the HS sync detector in the D-PHY receiver monitor's HS path.
- Uses the sync pulse and bit position to lock a bit offset for the burst, then emits byte-aligned payload with a valid strobe.
- Tracks burst activity and counts received payload bytes.
- Returns to idle when the HS enable drops at end of burst.

## Interface
- SYNC_POS_MAX, default 8: largest legal sync bit position.
- CNT_W, default 16: width of the payload byte counter.
- RxByteClkHS  in  1  HS byte clock; all logic on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Enable  in  1  HS receive window open; same signal that gates the sync detector.
- DataHS  in  8  raw deserialized HS byte, first-received bit in bit 0.
- RxSyncHS  in  1  one-cycle sync-found pulse from the sync detector.
- RxSyncPosition  in  4  bit offset of the sync character, 0..8.
- RxDataHS  out  8  aligned payload byte.
- RxValidHS  out  1  RxDataHS valid this cycle.
- RxActiveHS  out  1  burst locked, payload streaming.
- RxByteCount  out  CNT_W  payload bytes in the current or most recent burst.
- ErrSyncHS  out  1  present only with HS_ALIGN_ERR_EN; one-cycle sync error pulse.

## Operation
- States:
  - IDLE, entered when Enable=0.
  - HUNT, entered when Enable=1 and not yet locked.
  - ACTIVE, locked.
- IDLE → HUNT when Enable=1.
- HUNT → ACTIVE on RxSyncHS=1 with a legal position:
  - Latch offset <= RxSyncPosition.
  - Clear RxByteCount to 0.
- ACTIVE or HUNT → IDLE on Enable=0. Enable=0 has priority over RxSyncHS in the same cycle.
- prev_byte <= DataHS on every edge with Enable=1. It holds when Enable=0.
- Alignment window: W = {DataHS, prev_byte}, 16 bits. Aligned byte = W[offset +: 8].
  - offset 0 selects prev_byte.
  - offset 8 selects DataHS.
- In ACTIVE, on every edge:
  - RxDataHS <= aligned byte.
  - RxValidHS <= 1.
  - RxByteCount <= RxByteCount+1, saturating at all-ones.
- Outside ACTIVE:
  - RxValidHS <= 0.
  - RxDataHS holds its last value.
  - RxByteCount holds its last value until the next lock.
- RxActiveHS = 1 exactly while the state is ACTIVE. It is registered, decoded from state.
- RxSyncHS while in ACTIVE is ignored: offset is not re-latched and the counter is not cleared.
- A position > SYNC_POS_MAX is illegal; see Configuration.

## Timing
- Reset (Rst_n=0, asynchronous):
  - State IDLE, offset 0, prev_byte 8'h00.
  - RxDataHS 8'h00, RxValidHS 0, RxActiveHS 0, RxByteCount 0, ErrSyncHS 0.
- Sync sampled high at edge k: RxActiveHS is high after edge k.
- First valid byte: after edge k+1, RxValidHS=1 and RxDataHS={DataHS@k+1, DataHS@k}[offset+:8].
- Latency from raw byte to aligned output is one cycle. Throughput is one byte per cycle with no gaps.
- Enable sampled 0 at edge m: RxValidHS and RxActiveHS are 0 after edge m. The last valid byte is the one produced at edge m-1.
- Reset deasserted mid-burst: the block restarts in IDLE and requires a fresh sync. No partial byte is emitted.

## Configuration
- HS_ALIGN_ERR_EN defined:
  - ErrSyncHS port exists.
  - In HUNT, RxSyncHS with position > SYNC_POS_MAX pulses ErrSyncHS for one cycle and stays in HUNT.
  - In ACTIVE, RxSyncHS pulses ErrSyncHS for one cycle (unexpected re-sync) and the block stays ACTIVE.
- HS_ALIGN_ERR_EN undefined:
  - No ErrSyncHS port.
  - An illegal position is clamped to SYNC_POS_MAX and locks normally.
  - Re-sync in ACTIVE is silently ignored.

## Structure
- Shared HS receive package/header holds:
  - State encodings IDLE/HUNT/ACTIVE.
  - SYNC_POS_MAX.
  - The sync character constant 8'h1D, shared with the sync detector.
- One sub-module, hs_align_mux: purely combinational 16→8 offset select (W, offset → byte). It is reused by the multi-lane merger.
- The FSM, prev_byte register, offset latch and counter live in hs_byte_aligner.

## Test plan
- Reset mid-ACTIVE: drive Rst_n=0 while streaming. All outputs go to reset values immediately with no clock. After release the block stays in HUNT until a new RxSyncHS.
- Offset 8: sync at edge k, DataHS@k+1=8'hA5, DataHS@k+2=8'h3C. Expect RxDataHS 8'hA5 then 8'h3C with RxValidHS=1, and RxByteCount 1 then 2.
- Offset 4: DataHS@k=8'hA5, DataHS@k+1=8'h3C. Expect RxDataHS=8'hCA after edge k+1.
- End of burst: Enable low at edge m after 5 bytes. Expect RxValidHS=0 and RxActiveHS=0 after m, and RxByteCount holds 5. Enable=0 and RxSyncHS=1 in the same cycle gives IDLE.
- Illegal position 4'd9:
  - With HS_ALIGN_ERR_EN: one-cycle ErrSyncHS and the state stays HUNT.
  - Without it: locks with offset 8.
- Counter saturation (CNT_W=4 build): 20 bytes in ACTIVE. RxByteCount stops at 4'hF while RxValidHS remains high.
